vram_scanout: RTL and testbench

Display scanout engine for the MiniGPU frame buffers: generates raster timing, reads one byte per pixel from VRAM port B, and emits aligned pixel/sync/data-enable outputs. It is the read-side client of the dual-clock VRAM: the GPU writes through port A, and this block reads through port B in the pixel-clock domain. It also owns front-buffer selection for double buffering, and swaps buffers only at vertical blank.

---
 rtl/vram_scanout.sv | 200 ++++++++++++++++++++
 tb/tb_vram_scanout.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// vram_scanout
//   Display scanout engine. Generates raster timing, reads one byte per pixel
//   from VRAM port B, and emits pixel/sync/data-enable outputs that are all
//   aligned to the same 2-clock latency. The front buffer can be swapped, but
//   only at the start of vertical blank, so a visible frame never mixes buffers.
//
//   Optional feature macro: SCANOUT_DBUF_EN
//     defined   : double buffering (swap_req / swap_done / front_sel active)
//     undefined : single buffer at FB_BASE0, front_sel = swap_done = 0,
//                 swap_req ignored. Raster timing is identical in both builds.
//
// Ports
//   clk        in   pixel clock, all logic on rising edge
//   rst_n      in   synchronous reset, active-low
//   vram_addr  out  [17:0] read address to VRAM port B (combinational from regs)
//   vram_q     in   [7:0]  VRAM port B read data, one-cycle registered latency
//   swap_req   in   level request to swap the front buffer
//   swap_done  out  one-cycle pulse when a swap is applied
//   front_sel  out  current front buffer (0 = FB_BASE0, 1 = FB_BASE1)
//   hsync      out  horizontal sync, active-low
//   vsync      out  vertical sync, active-low
//   de         out  data enable, high on visible pixels
//   pixel      out  [7:0] pixel byte, 0 when de is low

module vram_scanout #(
  parameter int          H_ACTIVE = 256,
  parameter int          H_FP     = 8,
  parameter int          H_SYNC   = 32,
  parameter int          H_BP     = 24,
  parameter int          V_ACTIVE = 192,
  parameter int          V_FP     = 3,
  parameter int          V_SYNC   = 4,
  parameter int          V_BP     = 13,
  parameter logic [17:0] FB_BASE0 = 18'd0,
  parameter logic [17:0] FB_BASE1 = 18'd49152
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [17:0] vram_addr,
  input  logic [7:0]  vram_q,
  input  logic        swap_req,
  output logic        swap_done,
  output logic        front_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  // One extra bit so sync-end constants equal to the total still fit.
  localparam int HWX = HW + 1;
  localparam int VWX = VW + 1;

  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HWX-1:0] H_ACT_X   = HWX'(H_ACTIVE);
  localparam logic [VWX-1:0] V_ACT_X   = VWX'(V_ACTIVE);
  localparam logic [HWX-1:0] HS_BEG    = HWX'(H_ACTIVE + H_FP);
  localparam logic [HWX-1:0] HS_END    = HWX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VWX-1:0] VS_BEG    = VWX'(V_ACTIVE + V_FP);
  localparam logic [VWX-1:0] VS_END    = VWX'(V_ACTIVE + V_FP + V_SYNC);

  // Pipeline depth from counter position to outputs.
  localparam int STAGES = 2;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_end;

  assign h_wrap    = (h == H_LAST);
  assign v_wrap    = (v == V_LAST);
  assign frame_end = h_wrap & v_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= v_wrap ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Region decode for the current position (cycle n)
  // ---------------------------------------------------------------------------
  logic [HWX-1:0] hx;
  logic [VWX-1:0] vx;
  logic           active;
  logic           hs_n;
  logic           vs_n;

  assign hx     = {1'b0, h};
  assign vx     = {1'b0, v};
  assign active = (hx < H_ACT_X) && (vx < V_ACT_X);
  // Vertical sync is decided per whole line, so it only looks at v.
  assign hs_n   = !((hx >= HS_BEG) && (hx < HS_END));
  assign vs_n   = !((vx >= VS_BEG) && (vx < VS_END));

  // ---------------------------------------------------------------------------
  // Pixel index: running count of active pixels in this frame. Replaces the
  // v*H_ACTIVE+h product; the active region is contiguous in memory.
  // ---------------------------------------------------------------------------
  logic [17:0] pix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix <= '0;
    end else if (frame_end) begin
      pix <= '0;
    end else if (active) begin
      pix <= pix + 18'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Front buffer selection
  // ---------------------------------------------------------------------------
`ifdef SCANOUT_DBUF_EN
  logic pending;
  logic swap_pt;
  logic do_swap;

  // First cycle of the first blank line: the visible frame has been fully
  // fetched, and the next one has not started.
  assign swap_pt = (h == '0) && (vx == V_ACT_X);
  // A request in the swap-point cycle itself is honoured immediately.
  assign do_swap = swap_pt && (pending || swap_req);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        front_sel <= ~front_sel;
        pending   <= 1'b0;
      end else if (swap_req) begin
        // Any number of requests before a swap point collapse into one.
        pending   <= 1'b1;
      end
    end
  end

  assign vram_addr = (front_sel ? FB_BASE1 : FB_BASE0) + pix;
`else
  logic unused_swap_req;

  assign unused_swap_req = swap_req;
  assign front_sel       = 1'b0;
  assign swap_done       = 1'b0;
  assign vram_addr       = FB_BASE0 + pix;
`endif

  // ---------------------------------------------------------------------------
  // Output alignment pipeline
  //   stage 1 (end of n)   : capture de/hsync/vsync decode of position n
  //   stage 2 (end of n+1) : VRAM_Q for position n is valid; register all four
  // vld_pipe[k] / *_pipe[k] hold the position from k cycles earlier.
  // ---------------------------------------------------------------------------
  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] hs_pipe;
  logic [STAGES:1] vs_pipe;
  logic [7:0]      pix_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      pix_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], active};
      hs_pipe  <= {hs_pipe[STAGES-1:1], hs_n};
      vs_pipe  <= {vs_pipe[STAGES-1:1], vs_n};
      // Blank pixels are forced to zero; VRAM data there is meaningless.
      pix_q    <= vld_pipe[STAGES-1] ? vram_q : 8'h00;
    end
  end

  assign de    = vld_pipe[STAGES];
  assign hsync = hs_pipe[STAGES];
  assign vsync = vs_pipe[STAGES];
  assign pixel = pix_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Testbench for vram_scanout. Uses a reduced raster so several full frames fit
// in a short run; every output is compared each cycle against a reference
// computed from frame position arithmetic, plus directed boundary checks.
module tb_vram_scanout;

  localparam int HA  = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA  = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [17:0] B0 = 18'd0;
  localparam logic [17:0] B1 = 18'h3FFC0;  // base+pix wraps past 2^18

`ifdef SCANOUT_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] px;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        swap_req = 1'b0;
  logic [7:0]  vram_q = 8'h00;
  logic [17:0] vram_addr;
  logic        swap_done, front_sel, hsync, vsync, de;
  logic [7:0]  pixel;
  logic [7:0]  key = 8'h00;

  vram_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FB_BASE0(B0), .FB_BASE1(B1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vram_addr(vram_addr), .vram_q(vram_q),
    .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel)
  );

  always #5 clk = ~clk;

  // VRAM port B model: registered read, contents = addr[7:0] ^ key.
  always @(posedge clk) vram_q <= vram_addr[7:0] ^ key;

  int   n_assert = 0;
  int   n_fail = 0;
  int   t = 0;          // cycle index since reset release
  bit   front_m = 1'b0;
  bit   pend_m = 1'b0;
  bit   done_m = 1'b0;
  int   done_obs = 0;
  rec_t e1, e2;

  function automatic rec_t rst_rec();
    rec_t r;
    r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.px = 8'h00;
    return r;
  endfunction

  function automatic int hpos(int tt); return tt % HT; endfunction
  function automatic int vpos(int tt); return (tt / HT) % VT; endfunction

  // Address = base + number of visible pixels already fetched this frame.
  function automatic logic [17:0] exp_addr(int tt, bit fr);
    int h, v, p;
    h = hpos(tt); v = vpos(tt);
    p = (v >= VA) ? VA * HA : v * HA + ((h < HA) ? h : HA);
    return (fr ? B1 : B0) + 18'(p);
  endfunction

  function automatic rec_t mk(int tt, bit fr);
    rec_t r;
    int h, v;
    logic [17:0] a;
    h = hpos(tt); v = vpos(tt);
    a = exp_addr(tt, fr);
    r.de = (h < HA) && (v < VA);
    r.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
    r.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    r.px = r.de ? (a[7:0] ^ key) : 8'h00;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Advance one clock, update the reference, then compare every output.
  task automatic tick();
    bit rs, rq;
    int h, v;
    rs = rst_n;
    rq = swap_req;
    @(posedge clk);
    if (!rs) begin
      t = 0; front_m = 1'b0; pend_m = 1'b0; done_m = 1'b0;
      e1 = rst_rec(); e2 = rst_rec();
    end else begin
      h = hpos(t); v = vpos(t);
      e2 = e1;
      e1 = mk(t, front_m);
      done_m = 1'b0;
      if (DBUF) begin
        if (h == 0 && v == VA && (pend_m || rq)) begin
          front_m = ~front_m; pend_m = 1'b0; done_m = 1'b1;
        end else if (rq) begin
          pend_m = 1'b1;
        end
      end
      t++;
    end
    #1;
    chk("vram_addr", 32'(vram_addr), 32'(exp_addr(t, front_m)));
    chk("de", 32'(de), 32'(e2.de));
    chk("hsync", 32'(hsync), 32'(e2.hs));
    chk("vsync", 32'(vsync), 32'(e2.vs));
    chk("pixel", 32'(pixel), 32'(e2.px));
    chk("front_sel", 32'(front_sel), 32'(front_m));
    chk("swap_done", 32'(swap_done), 32'(done_m));
    if (swap_done === 1'b1) done_obs++;
  endtask

  // Run until the DUT is in the cycle at position (hh, vv); bounded.
  task automatic run_to(input int hh, input int vv);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (hpos(t) == hh && vpos(t) == vv) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("run_to_reached", 32'(found), 32'd1);
  endtask

  task automatic pulse_req();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    int hl, vl, dl;
    e1 = rst_rec(); e2 = rst_rec();

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);

    // Release: first pixel two cycles after the first post-reset cycle
    rst_n = 1'b1;
    tick();
    chk("de_t1", 32'(de), 32'd0);
    tick();
    chk("de_first", 32'(de), 32'd1);
    chk("pix_first", 32'(pixel), 32'h00);
    tick();
    chk("pix_second", 32'(pixel), 32'h01);

    // Sync/DE totals over exactly one frame of outputs
    hl = 0; vl = 0; dl = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (hsync === 1'b0) hl++;
      if (vsync === 1'b0) vl++;
      if (de === 1'b1) dl++;
      tick();
    end
    chk("hsync_low_cnt", 32'(hl), 32'(HS * VT));
    chk("vsync_low_cnt", 32'(vl), 32'(VS * HT));
    chk("de_cnt", 32'(dl), 32'(HA * VA));

    // Address boundaries
    run_to(0, 1);
    chk("addr_line1", 32'(vram_addr), 32'(B0 + 18'(HA)));
    run_to(HA - 1, VA - 1);
    chk("addr_last", 32'(vram_addr), 32'(B0 + 18'(HA * VA - 1)));
    run_to(0, 0);
    chk("addr_frame0", 32'(vram_addr), 32'(B0));

    // Single swap request mid-frame
    done_obs = 0;
    run_to(0, 2);
    pulse_req();
    run_to(HA - 1, VA - 1);
    chk("no_early_swap", 32'(front_sel), 32'd0);
    run_to(0, VA);
    chk("swap_pt_front", 32'(front_sel), 32'd0);
    tick();
    chk("swap_pulse", 32'(swap_done), 32'(DBUF));
    chk("swap_front", 32'(front_sel), 32'(DBUF));
    run_to(0, 0);
    chk("addr_after_swap", 32'(vram_addr), 32'(DBUF ? B1 : B0));
    chk("swap_once", 32'(done_obs), 32'(DBUF ? 1 : 0));

    // Three requests in one frame collapse into one toggle
    done_obs = 0;
    run_to(0, 1); pulse_req();
    run_to(3, 3); pulse_req();
    run_to(5, 5); pulse_req();
    run_to(0, 0);
    chk("collapse_cnt", 32'(done_obs), 32'(DBUF ? 1 : 0));
    chk("collapse_front", 32'(front_sel), 32'd0);

    // Pending request discarded by a mid-frame reset
    done_obs = 0;
    run_to(0, 2);
    pulse_req();
    run_to(0, 5);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (FRAME + 10) tick();
    chk("rst_discard_cnt", 32'(done_obs), 32'd0);
    chk("rst_discard_front", 32'(front_sel), 32'd0);

    // Random memory key and random request pattern
    rst_n = 1'b0;
    key = 8'($urandom);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      swap_req = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Request held high: one swap per frame
    done_obs = 0;
    swap_req = 1'b1;
    repeat (2 * FRAME) tick();
    swap_req = 1'b0;
    chk("held_swaps", 32'(done_obs), 32'(DBUF ? 2 : 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
